refill_arbiter: RTL and testbench

//  Shares one core's single memory read port between the instruction cache and data cache line-refill engines.

---
 rtl/refill_arbiter_pkg.sv | 20 ++
 rtl/refill_arbiter_rr_arbiter.sv | 32 +++
 rtl/refill_arbiter.sv | 119 +++++++++++
 tb/tb_refill_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/refill_arbiter_pkg.sv
// Shared types and constants for the cache refill arbiter.
package refill_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } refill_arb_state_t;

  localparam int unsigned REQ_ICACHE = 0;
  localparam int unsigned REQ_DCACHE = 1;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/refill_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import refill_arbiter_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (!any && req[IDX_W'(cand)]) begin
        gnt[IDX_W'(cand)] = 1'b1;
        idx               = IDX_W'(cand);
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one AXI read port between icache and dcache refill engines;
// one burst in flight, return beats forwarded combinationally to the granted requester.
module refill_arbiter
  import refill_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 8
) (
  input  logic                         i_aclk,
  input  logic                         i_reset,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] i_req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]     i_req_len,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [DATA_W-1:0]            o_rsp_data,
  output logic                         o_rsp_last,
  output logic                         o_rsp_err,
  output logic                         o_ar_valid,
  input  logic                         i_ar_ready,
  output logic [ADDR_SIZE-1:0]         o_ar_addr,
  output logic [LEN_W-1:0]             o_ar_len,
  input  logic                         i_r_valid,
  output logic                         o_r_ready,
  input  logic [DATA_W-1:0]            i_r_data,
  input  logic [1:0]                   i_r_resp,
  input  logic                         i_r_last
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  refill_arb_state_t  state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [LEN_W-1:0]   count;

  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  logic               beat;
  logic               len_hit;
  logic               burst_end;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (i_req_valid),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Burst terminates on whichever comes first: AXI last or the requested beat count.
  assign beat      = (state == ARB_DATA) && i_r_valid;
  assign len_hit   = (count == o_ar_len);
  assign burst_end = beat && (i_r_last || len_hit);

  assign o_rsp_data = i_r_data;
  assign o_rsp_last = burst_end;
  assign o_rsp_err  = beat && ((i_r_resp != AXI_RESP_OKAY) || (i_r_last != len_hit));

  always_comb begin
    o_rsp_valid = '0;
    if (beat) o_rsp_valid[gnt_idx] = 1'b1;
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      gnt_idx     <= '0;
      count       <= '0;
      o_req_ready <= '0;
      o_ar_valid  <= 1'b0;
      o_ar_addr   <= '0;
      o_ar_len    <= '0;
      o_r_ready   <= 1'b0;
    end else begin
      o_req_ready <= '0;
      case (state)
        ARB_IDLE: begin
          if (win_any) begin
            gnt_idx     <= win_idx;
            o_ar_addr   <= i_req_addr[32'(win_idx)*ADDR_SIZE +: ADDR_SIZE];
            o_ar_len    <= i_req_len[32'(win_idx)*LEN_W +: LEN_W];
            o_req_ready <= win_gnt;
            o_ar_valid  <= 1'b1;
            state       <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (i_ar_ready) begin
            o_ar_valid <= 1'b0;
            o_r_ready  <= 1'b1;
            count      <= '0;
            state      <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (i_r_valid) begin
            count <= count + LEN_W'(1);
            if (burst_end) begin
              o_r_ready <= 1'b0;
              state     <= ARB_IDLE;
              ptr       <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed self-checking bench for refill_arbiter.
module tb_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [15:0] req_len;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  refill_arbiter dut (
    .i_aclk      (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_len   (req_len),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_last  (rsp_last),
    .o_rsp_err   (rsp_err),
    .o_ar_valid  (ar_valid),
    .i_ar_ready  (ar_ready),
    .o_ar_addr   (ar_addr),
    .o_ar_len    (ar_len),
    .i_r_valid   (r_valid),
    .o_r_ready   (r_ready),
    .i_r_data    (r_data),
    .i_r_resp    (r_resp),
    .i_r_last    (r_last)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11;
    req_addr = {32'h0000_3000, 32'h0000_2000}; req_len = 16'h0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ar_valid !== 1'b0) begin bad++; $display("FAIL reset_ar_valid cyc=%0d got=%0h want=0", i, ar_valid); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready cyc=%0d got=%0h want=0", i, req_ready); end
      total++; if ({rsp_valid, rsp_last, rsp_err, r_ready} !== 5'b0) begin bad++; $display("FAIL reset_rsp cyc=%0d got=%0h want=0", i, {rsp_valid, rsp_last, rsp_err, r_ready}); end
      total++; if ({ar_addr, ar_len} !== 40'h0) begin bad++; $display("FAIL reset_ar_addr_len cyc=%0d got=%0h want=0", i, {ar_addr, ar_len}); end
    end
    rst = 1'b0; req_valid = 2'b00;
    tick();
    total++; if (ar_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_ar_valid got=%0h want=0", ar_valid); end
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_addr[31:0] = 32'h0000_1000; req_len[7:0] = 8'd3;
    tick();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_req_ready got=%0h want=1", req_ready); end
    total++; if ({ar_valid, ar_addr, ar_len} !== {1'b1, 32'h0000_1000, 8'd3}) begin bad++; $display("FAIL single_ar got=%0h want=%0h", {ar_valid, ar_addr, ar_len}, {1'b1, 32'h0000_1000, 8'd3}); end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({ar_valid, ar_addr, ar_len, req_ready} !== {1'b1, 32'h0000_1000, 8'd3, 2'b00}) begin bad++; $display("FAIL single_ar_hold cyc=%0d got=%0h want=%0h", i, {ar_valid, ar_addr, ar_len, req_ready}, {1'b1, 32'h0000_1000, 8'd3, 2'b00}); end
    end
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    total++; if ({ar_valid, r_ready} !== 2'b01) begin bad++; $display("FAIL single_enter_data got=%0h want=1", {ar_valid, r_ready}); end
    for (int b = 0; b < 4; b++) begin
      r_valid = 1'b1; r_data = 32'hA000_0000 + 32'(b); r_last = (b == 3); r_resp = 2'b00;
      #1;
      total++; if ({rsp_valid, rsp_data} !== {2'b01, 32'hA000_0000 + 32'(b)}) begin bad++; $display("FAIL single_beat%0d got=%0h want=%0h", b, {rsp_valid, rsp_data}, {2'b01, 32'hA000_0000 + 32'(b)}); end
      total++; if ({rsp_last, rsp_err} !== {(b == 3), 1'b0}) begin bad++; $display("FAIL single_last_err%0d got=%0h want=%0h", b, {rsp_last, rsp_err}, {(b == 3), 1'b0}); end
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0;
    #1;
    total++; if ({r_ready, rsp_valid} !== 3'b0) begin bad++; $display("FAIL single_back_idle got=%0h want=0", {r_ready, rsp_valid}); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11; req_addr = {32'h0000_3000, 32'h0000_2000}; req_len = {8'd0, 8'd1};
    tick();
    total++; if ({req_ready, ar_addr} !== {2'b01, 32'h0000_2000}) begin bad++; $display("FAIL rr_first_grant got=%0h want=%0h", {req_ready, ar_addr}, {2'b01, 32'h0000_2000}); end
    req_valid = 2'b10; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      r_valid = 1'b1; r_data = 32'h1100 + 32'(b); r_last = (b == 1);
      #1;
      total++; if ({rsp_valid, rsp_last} !== {2'b01, (b == 1)}) begin bad++; $display("FAIL rr_icache_beat%0d got=%0h want=%0h", b, {rsp_valid, rsp_last}, {2'b01, (b == 1)}); end
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0;
    total++; if ({ar_valid, req_ready, r_ready} !== 4'b0) begin bad++; $display("FAIL rr_idle_gap got=%0h want=0", {ar_valid, req_ready, r_ready}); end
    tick();
    total++; if ({req_ready, ar_valid, ar_addr, ar_len} !== {2'b10, 1'b1, 32'h0000_3000, 8'd0}) begin bad++; $display("FAIL rr_dcache_grant got=%0h want=%0h", {req_ready, ar_valid, ar_addr, ar_len}, {2'b10, 1'b1, 32'h0000_3000, 8'd0}); end
    req_valid = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    r_valid = 1'b1; r_last = 1'b1; r_data = 32'h2200;
    #1;
    total++; if ({rsp_valid, rsp_last, rsp_err} !== {2'b10, 1'b1, 1'b0}) begin bad++; $display("FAIL rr_dcache_single got=%0h want=%0h", {rsp_valid, rsp_last, rsp_err}, {2'b10, 1'b1, 1'b0}); end
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    req_valid = 2'b11;
    tick();
    total++; if ({req_ready, ar_addr} !== {2'b01, 32'h0000_2000}) begin bad++; $display("FAIL rr_rotate got=%0h want=%0h", {req_ready, ar_addr}, {2'b01, 32'h0000_2000}); end
    req_valid = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      r_valid = 1'b1; r_last = (b == 1);
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0;
  endtask

  task automatic test_error();
    req_valid = 2'b01; req_addr[31:0] = 32'h0000_4000; req_len[7:0] = 8'd3;
    tick();
    req_valid = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      r_valid = 1'b1; r_last = (b == 3); r_resp = (b == 1) ? 2'b10 : 2'b00;
      #1;
      total++; if ({rsp_valid, rsp_last, rsp_err} !== {2'b01, (b == 3), (b == 1)}) begin bad++; $display("FAIL err_beat%0d got=%0h want=%0h", b, {rsp_valid, rsp_last, rsp_err}, {2'b01, (b == 3), (b == 1)}); end
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
    total++; if (r_ready !== 1'b0) begin bad++; $display("FAIL err_done got=%0h want=0", r_ready); end
  endtask

  task automatic test_len_mismatch();
    req_valid = 2'b10; req_addr[63:32] = 32'h0000_6000; req_len[15:8] = 8'd3;
    tick();
    total++; if ({req_ready, ar_len} !== {2'b10, 8'd3}) begin bad++; $display("FAIL mis_grant got=%0h want=%0h", {req_ready, ar_len}, {2'b10, 8'd3}); end
    req_valid = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      r_valid = 1'b1; r_last = (b == 1);
      #1;
      total++; if ({rsp_valid, rsp_last, rsp_err} !== {2'b10, (b == 1), (b == 1)}) begin bad++; $display("FAIL mis_beat%0d got=%0h want=%0h", b, {rsp_valid, rsp_last, rsp_err}, {2'b10, (b == 1), (b == 1)}); end
      tick();
    end
    r_last = 1'b0;
    #1;
    total++; if ({rsp_valid, r_ready, ar_valid} !== 4'b0) begin bad++; $display("FAIL mis_idle got=%0h want=0", {rsp_valid, r_ready, ar_valid}); end
    r_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10; req_addr[63:32] = 32'h0000_7000; req_len[15:8] = 8'd3;
    tick();
    req_valid = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    r_valid = 1'b1; r_last = 1'b0;
    #1;
    total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL rstmid_beat0 got=%0h want=2", rsp_valid); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_last = (i == 1);
      #1;
      total++; if ({rsp_valid, rsp_last, r_ready, ar_valid} !== 5'b0) begin bad++; $display("FAIL rstmid_quiet%0d got=%0h want=0", i, {rsp_valid, rsp_last, r_ready, ar_valid}); end
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0;
    req_valid = 2'b10; req_addr[63:32] = 32'h0000_5000; req_len[15:8] = 8'd0;
    tick();
    total++; if ({req_ready, ar_valid, ar_addr, ar_len} !== {2'b10, 1'b1, 32'h0000_5000, 8'd0}) begin bad++; $display("FAIL rstmid_regrant got=%0h want=%0h", {req_ready, ar_valid, ar_addr, ar_len}, {2'b10, 1'b1, 32'h0000_5000, 8'd0}); end
    req_valid = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    r_valid = 1'b1; r_last = 1'b1; r_data = 32'h0000_BEEF;
    #1;
    total++; if ({rsp_valid, rsp_data, rsp_last, rsp_err} !== {2'b10, 32'h0000_BEEF, 1'b1, 1'b0}) begin bad++; $display("FAIL rstmid_beat got=%0h want=%0h", {rsp_valid, rsp_data, rsp_last, rsp_err}, {2'b10, 32'h0000_BEEF, 1'b1, 1'b0}); end
    tick();
    r_valid = 1'b0; r_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_addr = '0; req_len = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_error();
    test_len_mismatch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
